pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

- Generates the per-stage `stall`/`clr` controls for the five-stage fe/id/ex/me/wb pipeline.
- Handles four conditions:
  - load-use hazards, one bubble;
  - taken-branch flush;
  - multi-cycle data-memory waits;
  - a sticky fault on memory error or timeout.
- Instantiated once in the pipeline top. All ten stage control nets come from this block.
- All other RAW hazards are resolved by forwarding outside this block.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum consecutive `MEM_CODE_WAIT` cycles before fault (1..65535).
- `CNT_W`, 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock, rising edge. One clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `i_id_rs1`, `i_id_rs2`  in  `REG_IDX_W`  source registers of the instruction in id.
- `i_id_rs1_en`, `i_id_rs2_en`  in  1  source actually read.
- `i_ex_dest_reg`  in  `REG_IDX_W`  destination register of the instruction in ex.
- `i_ex_dest_src`  in  `DEST_SRC_W`  writeback source of the ex instruction; `DEST_SRC_MEM` marks a load.
- `i_ex_branch_taken`  in  1  ex instruction is a resolved taken branch/jump.
- `i_me_mem_op`  in  1  me holds a load/store awaiting response.
- `i_mem_res_code`  in  `MEM_CODE_W`  memory response code.
- `o_fe_stall`, `o_id_stall`, `o_ex_stall`, `o_me_stall`, `o_wb_stall`  out  1  hold stage register.
- `o_fe_clr`, `o_id_clr`, `o_ex_clr`, `o_me_clr`, `o_wb_clr`  out  1  load bubble into stage register.
- `o_fault`  out  1  sticky fault.
- `o_stall_cnt`  out  `CNT_W`  saturating count of cycles with `o_fe_stall`=1.

## Operation
- FSM states:
  - `S_RUN`: normal flow.
  - `S_WAIT`: memory wait in progress.
  - `S_FAULT`: terminal; left only by reset.
- Control outputs are combinational from state and inputs. State, wait counter and `o_stall_cnt` are registered.
- Priority, highest first: fault, memory wait, branch flush, load-use.
- Memory response codes:
  - `MEM_CODE_OK`=0: done.
  - `MEM_CODE_WAIT`=1: pending.
  - `MEM_CODE_ERR`=2: error.
  - 3: reserved; treated as ERR.
- Memory wait:
  - Trigger: `i_me_mem_op`=1 and code=WAIT, in `S_RUN` or `S_WAIT`.
  - Asserts fe/id/ex/me stall and `o_wb_clr`.
  - `S_RUN`→`S_WAIT` on the first such cycle; the wait counter loads 1.
  - In `S_WAIT`, code=OK releases all stalls in the same cycle and moves to `S_RUN`; the counter clears.
  - Counter == `TIMEOUT` while still WAIT: move to `S_FAULT`.
- Error:
  - `i_me_mem_op`=1 and code=ERR in any state: move to `S_FAULT` next edge.
  - That cycle already drives the fault outputs combinationally.
- Fault outputs, driven in `S_FAULT` and combinationally in the ERR cycle:
  - all five stalls=1;
  - `o_wb_clr`=1;
  - other clr=0;
  - `o_fault`=1 (asserted from the next edge onward).
- Branch flush (no wait or fault active): `i_ex_branch_taken`=1 asserts `o_id_clr` and `o_ex_clr` for that cycle. This squashes the two wrong-path instructions; fe redirect is handled elsewhere.
- Load-use hazard:
  - Condition: `i_ex_dest_src`==`DEST_SRC_MEM`, `i_ex_dest_reg`≠0, and a matching enabled rs1 or rs2.
  - Response: `o_fe_stall`=`o_id_stall`=1, `o_ex_clr`=1 for one cycle.
  - Suppressed by a simultaneous branch flush.
- A branch stalled in ex during a wait keeps `i_ex_branch_taken` high; the flush occurs in the release cycle.
- `o_stall_cnt` increments on every edge where `o_fe_stall`=1 and saturates at all-ones.

## Timing
- Reset, asynchronous and active-low. While `aresetn`=0:
  - state=`S_RUN`, counters=0, `o_fault`=0;
  - all stalls 0;
  - all five clr=1.
- First edge after release: normal `S_RUN` outputs.
- Reset asserted mid-wait or in fault returns immediately to the reset values above.
- Latency: zero cycles from input to control output. Responses are visible in the same cycle and take effect at the next edge.
- Wait counter width is 16 bits. With code held at WAIT, the timeout fault occurs at the edge ending the `TIMEOUT`-th WAIT cycle.
- Code=OK on the first memory cycle: no stall at all.

## Structure
- `MEM_CODE_*` and `MEM_CODE_W` live in the shared memory-codes header.
- `DEST_SRC_*`, `DEST_SRC_W` and `REG_IDX_W` live in the shared config/opcode headers.
- State encodings are local parameters.
- One sub-module, `load_use_detect`: combinational comparator, rs1/rs2 vs ex dest.

## Test plan
- Load x5 in ex, id reads rs2=x5 with `i_id_rs2_en`=1 → one cycle `o_fe_stall`=`o_id_stall`=`o_ex_clr`=1, then clean. Repeat with rd=x0 → no stall.
- `i_me_mem_op`=1, code=WAIT for 3 cycles then OK → fe/id/ex/me stall and `o_wb_clr` high exactly 3 cycles; `o_stall_cnt`=3.
- Branch taken and load-use together → only `o_id_clr`/`o_ex_clr`, no stall.
- Branch taken during a 2-cycle wait → stalls only; `o_id_clr`/`o_ex_clr` in the release cycle.
- `TIMEOUT`=4 with WAIT held → `o_fault`=1 after the 4th WAIT cycle; all stalls stay high. Code=ERR → fault next edge.
- `aresetn` pulsed low during `S_WAIT` and during `S_FAULT` → immediately all clr=1, stalls 0, `o_fault`=0, `o_stall_cnt`=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: register index,
// writeback source, memory response codes and controller states.
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int DEST_SRC_W = 2;
    localparam int MEM_CODE_W = 2;
    localparam int WAIT_CNT_W = 16;

    localparam logic [DEST_SRC_W-1:0] DEST_SRC_ALU = 2'd0;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_MEM = 2'd1;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_PC  = 2'd2;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_CSR = 2'd3;

    localparam logic [MEM_CODE_W-1:0] MEM_CODE_OK   = 2'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_WAIT = 2'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_ERR  = 2'd2;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags an id-stage source register that
// depends on a load currently in ex.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0]  id_rs1,
    input  logic [REG_IDX_W-1:0]  id_rs2,
    input  logic                  id_rs1_en,
    input  logic                  id_rs2_en,
    input  logic [REG_IDX_W-1:0]  ex_dest_reg,
    input  logic [DEST_SRC_W-1:0] ex_dest_src,
    output logic                  hazard
);

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load into it never creates a dependency.
    assign ex_is_load = (ex_dest_src == DEST_SRC_MEM) && (ex_dest_reg != '0);
    assign rs1_hit    = id_rs1_en && (id_rs1 == ex_dest_reg);
    assign rs2_hit    = id_rs2_en && (id_rs2 == ex_dest_reg);
    assign hazard     = ex_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Per-stage stall/clear generation for the fe/id/ex/me/wb pipeline:
// sticky fault, memory wait with timeout, branch flush and load-use bubble.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [REG_IDX_W-1:0]  i_id_rs1,
    input  logic [REG_IDX_W-1:0]  i_id_rs2,
    input  logic                  i_id_rs1_en,
    input  logic                  i_id_rs2_en,
    input  logic [REG_IDX_W-1:0]  i_ex_dest_reg,
    input  logic [DEST_SRC_W-1:0] i_ex_dest_src,
    input  logic                  i_ex_branch_taken,
    input  logic                  i_me_mem_op,
    input  logic [MEM_CODE_W-1:0] i_mem_res_code,
    output logic                  o_fe_stall,
    output logic                  o_id_stall,
    output logic                  o_ex_stall,
    output logic                  o_me_stall,
    output logic                  o_wb_stall,
    output logic                  o_fe_clr,
    output logic                  o_id_clr,
    output logic                  o_ex_clr,
    output logic                  o_me_clr,
    output logic                  o_wb_clr,
    output logic                  o_fault,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(TIMEOUT);

    hz_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]      stall_cnt_q;
    logic                  load_use;
    logic                  mem_wait;
    logic                  mem_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    load_use_detect u_load_use_detect (
        .id_rs1      (i_id_rs1),
        .id_rs2      (i_id_rs2),
        .id_rs1_en   (i_id_rs1_en),
        .id_rs2_en   (i_id_rs2_en),
        .ex_dest_reg (i_ex_dest_reg),
        .ex_dest_src (i_ex_dest_src),
        .hazard      (load_use)
    );

    // The reserved code is folded into ERR so any unknown response is fatal.
    assign mem_wait = i_me_mem_op && (i_mem_res_code == MEM_CODE_WAIT);
    assign mem_err  = i_me_mem_op && (i_mem_res_code != MEM_CODE_OK)
                                  && (i_mem_res_code != MEM_CODE_WAIT);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        o_fe_stall = 1'b0;
        o_id_stall = 1'b0;
        o_ex_stall = 1'b0;
        o_me_stall = 1'b0;
        o_wb_stall = 1'b0;
        o_fe_clr   = 1'b0;
        o_id_clr   = 1'b0;
        o_ex_clr   = 1'b0;
        o_me_clr   = 1'b0;
        o_wb_clr   = 1'b0;

        if (!aresetn) begin
            // Hold every stage register empty while reset is asserted.
            o_fe_clr = 1'b1;
            o_id_clr = 1'b1;
            o_ex_clr = 1'b1;
            o_me_clr = 1'b1;
            o_wb_clr = 1'b1;
        end else if (state_q == S_FAULT || mem_err) begin
            state_d    = S_FAULT;
            o_fe_stall = 1'b1;
            o_id_stall = 1'b1;
            o_ex_stall = 1'b1;
            o_me_stall = 1'b1;
            o_wb_stall = 1'b1;
            o_wb_clr   = 1'b1;
        end else if (mem_wait) begin
            // wait_cnt_d counts WAIT cycles including this one.
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
            state_d    = (wait_cnt_d == TIMEOUT_C) ? S_FAULT : S_WAIT;
            o_fe_stall = 1'b1;
            o_id_stall = 1'b1;
            o_ex_stall = 1'b1;
            o_me_stall = 1'b1;
            o_wb_clr   = 1'b1;
        end else begin
            state_d    = S_RUN;
            wait_cnt_d = '0;
            if (i_ex_branch_taken) begin
                o_id_clr = 1'b1;
                o_ex_clr = 1'b1;
            end else if (load_use) begin
                o_fe_stall = 1'b1;
                o_id_stall = 1'b1;
                o_ex_clr   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (o_fe_stall) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign o_fault     = (state_q == S_FAULT);
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 32;

    logic                  clk = 1'b0;
    logic                  aresetn = 1'b1;
    logic [REG_IDX_W-1:0]  id_rs1, id_rs2, ex_dest_reg;
    logic                  rs1_en, rs2_en;
    logic [DEST_SRC_W-1:0] ex_dest_src;
    logic                  br_taken, mem_op;
    logic [MEM_CODE_W-1:0] mem_code;
    logic fe_stall, id_stall, ex_stall, me_stall, wb_stall;
    logic fe_clr, id_clr, ex_clr, me_clr, wb_clr;
    logic                  fault;
    logic [CNT_W-1:0]      stall_cnt;
    logic [9:0]            dut_ctrl;

    int checks = 0;
    int errors = 0;

    // Model state: sticky fault, length of the current WAIT run, stall cycles.
    bit          m_fault;
    int          m_wait_run;
    longint      m_scnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .i_id_rs1          (id_rs1),
        .i_id_rs2          (id_rs2),
        .i_id_rs1_en       (rs1_en),
        .i_id_rs2_en       (rs2_en),
        .i_ex_dest_reg     (ex_dest_reg),
        .i_ex_dest_src     (ex_dest_src),
        .i_ex_branch_taken (br_taken),
        .i_me_mem_op       (mem_op),
        .i_mem_res_code    (mem_code),
        .o_fe_stall        (fe_stall),
        .o_id_stall        (id_stall),
        .o_ex_stall        (ex_stall),
        .o_me_stall        (me_stall),
        .o_wb_stall        (wb_stall),
        .o_fe_clr          (fe_clr),
        .o_id_clr          (id_clr),
        .o_ex_clr          (ex_clr),
        .o_me_clr          (me_clr),
        .o_wb_clr          (wb_clr),
        .o_fault           (fault),
        .o_stall_cnt       (stall_cnt)
    );

    // {fe,id,ex,me,wb stall, fe,id,ex,me,wb clr}
    assign dut_ctrl = {fe_stall, id_stall, ex_stall, me_stall, wb_stall,
                       fe_clr, id_clr, ex_clr, me_clr, wb_clr};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_err();
        return mem_op && (mem_code >= 2);
    endfunction

    function automatic bit in_wait();
        return mem_op && (mem_code == 1);
    endfunction

    function automatic logic [9:0] model_ctrl();
        bit lu;
        lu = (ex_dest_src == DEST_SRC_MEM) && (ex_dest_reg != 0) &&
             ((rs1_en && id_rs1 == ex_dest_reg) || (rs2_en && id_rs2 == ex_dest_reg));
        if (m_fault || in_err()) return 10'b11111_00001;
        if (in_wait())           return 10'b11110_00001;
        if (br_taken)            return 10'b00000_01100;
        if (lu)                  return 10'b11000_00100;
        return 10'b00000_00000;
    endfunction

    task automatic drive(input logic [REG_IDX_W-1:0] r1, input logic e1,
                         input logic [REG_IDX_W-1:0] r2, input logic e2,
                         input logic [REG_IDX_W-1:0] rd, input logic [DEST_SRC_W-1:0] src,
                         input logic br, input logic mo, input logic [MEM_CODE_W-1:0] cd);
        id_rs1 = r1; rs1_en = e1; id_rs2 = r2; rs2_en = e2;
        ex_dest_reg = rd; ex_dest_src = src; br_taken = br;
        mem_op = mo; mem_code = cd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, DEST_SRC_ALU, 0, 0, MEM_CODE_OK);
    endtask

    // Compare one cycle's outputs, then advance the model across the edge.
    task automatic cycle(input string tag);
        logic [9:0] exp;
        bit err, wt;
        #1;
        exp = model_ctrl();
        err = in_err();
        wt  = in_wait();
        check({tag, "/ctrl"}, dut_ctrl, exp);
        check({tag, "/fault"}, fault, m_fault);
        check({tag, "/cnt"}, stall_cnt, m_scnt);
        @(posedge clk);
        if (!m_fault) begin
            if (err) m_fault = 1;
            else if (wt) begin
                m_wait_run++;
                if (m_wait_run >= TIMEOUT) m_fault = 1;
            end else m_wait_run = 0;
        end
        if (exp[9] && m_scnt < 64'hFFFF_FFFF) m_scnt++;
        #1;
    endtask

    // Reset is asserted with the current inputs still applied.
    task automatic do_reset(input string tag);
        aresetn = 1'b0;
        #1;
        check({tag, "/ctrl"}, dut_ctrl, 10'b00000_11111);
        check({tag, "/fault"}, fault, 1'b0);
        check({tag, "/cnt"}, stall_cnt, 0);
        m_fault = 0; m_wait_run = 0; m_scnt = 0;
        idle();
        #2 aresetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p;
        idle();
        @(posedge clk);
        #1;
        do_reset("rst0");

        // Load-use on rs2, then the bubble has moved on.
        drive(1, 1, 5, 1, 5, DEST_SRC_MEM, 0, 0, MEM_CODE_OK);
        #1 check("lu_direct", dut_ctrl, 10'b11000_00100);
        cycle("lu");
        drive(1, 1, 5, 1, 7, DEST_SRC_ALU, 0, 0, MEM_CODE_OK);
        cycle("lu_after");
        drive(0, 0, 0, 1, 0, DEST_SRC_MEM, 0, 0, MEM_CODE_OK);
        #1 check("lu_x0", dut_ctrl, 10'b00000_00000);
        cycle("lu_x0");
        drive(3, 0, 3, 0, 3, DEST_SRC_MEM, 0, 0, MEM_CODE_OK);
        cycle("lu_noen");

        // Three WAIT cycles then OK.
        do_reset("rst_w");
        repeat (3) begin
            drive(0, 0, 0, 0, 0, DEST_SRC_ALU, 0, 1, MEM_CODE_WAIT);
            cycle("wait3");
        end
        drive(0, 0, 0, 0, 0, DEST_SRC_ALU, 0, 1, MEM_CODE_OK);
        #1 check("wait_release", dut_ctrl, 10'b00000_00000);
        check("wait_cnt3", stall_cnt, 3);
        cycle("wait_ok");

        // Branch overrides load-use.
        drive(2, 1, 0, 0, 2, DEST_SRC_MEM, 1, 0, MEM_CODE_OK);
        #1 check("br_lu", dut_ctrl, 10'b00000_01100);
        cycle("br_lu");

        // Branch held through a 2-cycle wait flushes at release.
        repeat (2) begin
            drive(0, 0, 0, 0, 0, DEST_SRC_ALU, 1, 1, MEM_CODE_WAIT);
            cycle("br_wait");
        end
        drive(0, 0, 0, 0, 0, DEST_SRC_ALU, 1, 1, MEM_CODE_OK);
        #1 check("br_release", dut_ctrl, 10'b00000_01100);
        cycle("br_release");

        // Timeout fault after TIMEOUT WAIT cycles, then reset out of fault.
        do_reset("rst_to");
        repeat (TIMEOUT) begin
            drive(0, 0, 0, 0, 0, DEST_SRC_ALU, 0, 1, MEM_CODE_WAIT);
            cycle("timeout");
        end
        #1 check("timeout_fault", fault, 1'b1);
        repeat (2) begin
            drive(4, 1, 0, 0, 4, DEST_SRC_MEM, 1, 0, MEM_CODE_OK);
            cycle("fault_hold");
        end
        do_reset("rst_fault");

        // ERR and reserved code both fault on the next edge.
        drive(0, 0, 0, 0, 0, DEST_SRC_ALU, 0, 1, MEM_CODE_ERR);
        #1 check("err_comb", dut_ctrl, 10'b11111_00001);
        check("err_nofault_yet", fault, 1'b0);
        cycle("err");
        idle();
        cycle("err_after");
        do_reset("rst_err");
        drive(0, 0, 0, 0, 0, DEST_SRC_ALU, 0, 1, 2'd3);
        cycle("rsvd");
        idle();
        cycle("rsvd_after");
        do_reset("rst_rsvd");

        // Reset in the middle of a wait.
        repeat (2) begin
            drive(0, 0, 0, 0, 0, DEST_SRC_ALU, 0, 1, MEM_CODE_WAIT);
            cycle("wait_pre_rst");
        end
        drive(0, 0, 0, 0, 0, DEST_SRC_ALU, 0, 1, MEM_CODE_WAIT);
        do_reset("rst_wait");
        idle();
        cycle("post_rst");

        // Randomized traffic.
        for (int r = 0; r < 25; r++) begin
            for (int c = 0; c < 30; c++) begin
                p = $urandom_range(0, 99);
                drive(REG_IDX_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      REG_IDX_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      REG_IDX_W'($urandom_range(0, 3)), DEST_SRC_W'($urandom_range(0, 3)),
                      1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 1)),
                      (p < 60) ? 2'd0 : (p < 95) ? 2'd1 : (p < 98) ? 2'd2 : 2'd3);
                cycle("rnd");
            end
            do_reset("rnd_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
